// File: rtl/popcount_frame_stats_if.sv
// Bundles the popcount stream and the frame statistics outputs.
// Latency: none; this is wiring only.
// Backpressure: none; the producer drives counts whenever it has them.
interface popcount_frame_stats_if #(
  parameter int WIDTH     = 256,
  parameter int FRAME_LEN = 16
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int SW = $clog2(WIDTH * FRAME_LEN + 1);
  localparam int NW = $clog2(FRAME_LEN + 1);

  logic [CW-1:0] data_i;
  logic          data_val_i;
  logic          flush_i;
  logic [SW-1:0] sum_o;
  logic [CW-1:0] min_o;
  logic [CW-1:0] max_o;
  logic [NW-1:0] words_o;
  logic          stats_val_o;

  // Producer side: drives counts and flush, observes the statistics.
  modport master (
    output data_i, data_val_i, flush_i,
    input  sum_o, min_o, max_o, words_o, stats_val_o
  );

  // Statistics block side.
  modport slave (
    input  data_i, data_val_i, flush_i,
    output sum_o, min_o, max_o, words_o, stats_val_o
  );
endinterface

// File: rtl/popcount_frame_stats.sv
// Per-frame sum/min/max/word-count of a stream of popcounts.
// Latency: 1 clock from the closing count (or flush) to stats_val_o.
// Backpressure: none; a count is accepted on every cycle data_val_i is high.
module popcount_frame_stats #(
  parameter int WIDTH     = 256,
  parameter int FRAME_LEN = 16
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  popcount_frame_stats_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int SW = $clog2(WIDTH * FRAME_LEN + 1);
  localparam int NW = $clog2(FRAME_LEN + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] acc_sum;
  logic [CW-1:0] acc_min;
  logic [CW-1:0] acc_max;
  logic [NW-1:0] acc_n;

  logic [SW-1:0] nxt_sum;
  logic [CW-1:0] nxt_min;
  logic [CW-1:0] nxt_max;
  logic [NW-1:0] nxt_n;
  logic          close;

  // Frame totals including this cycle's count, and whether the frame ends here.
  always_comb begin
    nxt_sum = acc_sum;
    nxt_min = acc_min;
    nxt_max = acc_max;
    nxt_n   = acc_n;
    if (bus.data_val_i) begin
      if (state == IDLE) begin
        nxt_sum = SW'(bus.data_i);
        nxt_min = bus.data_i;
        nxt_max = bus.data_i;
        nxt_n   = NW'(1);
      end else begin
        nxt_sum = acc_sum + SW'(bus.data_i);
        nxt_min = (bus.data_i < acc_min) ? bus.data_i : acc_min;
        nxt_max = (bus.data_i > acc_max) ? bus.data_i : acc_max;
        nxt_n   = acc_n + NW'(1);
      end
    end
    // A flush in IDLE with nothing arriving has no frame to close.
    close = (bus.data_val_i && (nxt_n == NW'(FRAME_LEN)))
         || (bus.flush_i && ((state == ACCUM) || bus.data_val_i));
  end

  // Accumulate, publish on close, and restart the next frame from empty.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state           <= IDLE;
      acc_sum         <= '0;
      acc_min         <= '0;
      acc_max         <= '0;
      acc_n           <= '0;
      bus.sum_o       <= '0;
      bus.min_o       <= '0;
      bus.max_o       <= '0;
      bus.words_o     <= '0;
      bus.stats_val_o <= 1'b0;
    end else begin
      bus.stats_val_o <= close;
      if (close) begin
        bus.sum_o   <= nxt_sum;
        bus.min_o   <= nxt_min;
        bus.max_o   <= nxt_max;
        bus.words_o <= nxt_n;
        state       <= IDLE;
        acc_sum     <= '0;
        acc_min     <= '0;
        acc_max     <= '0;
        acc_n       <= '0;
      end else if (bus.data_val_i) begin
        state   <= ACCUM;
        acc_sum <= nxt_sum;
        acc_min <= nxt_min;
        acc_max <= nxt_max;
        acc_n   <= nxt_n;
      end
    end
  end
endmodule

// File: tb/tb_popcount_frame_stats.sv
// Directed-vector bench for popcount_frame_stats with WIDTH=256, FRAME_LEN=4.
// Each vector row is one clock of inputs plus the outputs expected after that edge.
// Hand-written sequence afterwards checks pulse latency and uniqueness.
module tb_popcount_frame_stats;
  localparam int WIDTH     = 256;
  localparam int FRAME_LEN = 4;

  logic clk_i  = 1'b0;
  logic srst_i = 1'b1;

  popcount_frame_stats_if #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) bus ();

  popcount_frame_stats #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic     rst;
    logic     val;
    logic     flush;
    int       data;
    logic     e_val;
    int       e_sum;
    int       e_min;
    int       e_max;
    int       e_words;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rst, input logic val, input logic flush, input int data,
                     input logic e_val, input int e_sum, input int e_min, input int e_max,
                     input int e_words);
    vec_t v;
    v.rst = rst; v.val = val; v.flush = flush; v.data = data;
    v.e_val = e_val; v.e_sum = e_sum; v.e_min = e_min; v.e_max = e_max; v.e_words = e_words;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int pulses;
    int pulse_cycle;
    int seen_sum;

    // rst val flush data | val sum min max words
    add(1, 0, 0,   0,  0,   0,  0,   0, 0);  // reset state
    add(1, 0, 0,   0,  0,   0,  0,   0, 0);
    add(0, 1, 0,  10,  0,   0,  0,   0, 0);  // full frame 10,200,0,256
    add(0, 1, 0, 200,  0,   0,  0,   0, 0);
    add(0, 1, 0,   0,  0,   0,  0,   0, 0);
    add(0, 1, 0, 256,  1, 466,  0, 256, 4);
    add(0, 0, 0,   0,  0, 466,  0, 256, 4);  // outputs hold
    add(0, 1, 0,   5,  0, 466,  0, 256, 4);  // 5,7 then flush without data
    add(0, 1, 0,   7,  0, 466,  0, 256, 4);
    add(0, 0, 1,   0,  1,  12,  5,   7, 2);
    add(0, 0, 0,   0,  0,  12,  5,   7, 2);
    for (int i = 0; i < 8; i++)              // 8 back-to-back threes
      add(0, 1, 0, 3, (i % 4) == 3, (i < 3) ? 12 : 12, (i < 3) ? 5 : 3,
          (i < 3) ? 7 : 3, (i < 3) ? 2 : 4);
    add(0, 0, 0,   0,  0,  12,  3,   3, 4);
    add(0, 0, 1,   0,  0,  12,  3,   3, 4);  // flush in IDLE, no data: nothing
    add(0, 1, 1,   9,  1,   9,  9,   9, 1);  // flush with data in IDLE: 1-word frame
    add(0, 0, 0,   0,  0,   9,  9,   9, 1);
    add(0, 1, 0,   1,  0,   9,  9,   9, 1);  // partial frame then reset
    add(0, 1, 0,   2,  0,   9,  9,   9, 1);
    add(1, 0, 0,   0,  0,   0,  0,   0, 0);
    add(0, 1, 0,   4,  0,   0,  0,   0, 0);
    add(0, 1, 0,   4,  0,   0,  0,   0, 0);
    add(0, 1, 0,   4,  0,   0,  0,   0, 0);
    add(0, 1, 0,   4,  1,  16,  4,   4, 4);
    add(0, 0, 0,   0,  0,  16,  4,   4, 4);
    add(0, 1, 0,  50,  0,  16,  4,   4, 4);  // flush on the 4th count
    add(0, 1, 0,  50,  0,  16,  4,   4, 4);
    add(0, 1, 0,  50,  0,  16,  4,   4, 4);
    add(0, 1, 1,  50,  1, 200, 50,  50, 4);
    add(0, 0, 0,   0,  0, 200, 50,  50, 4);
    add(0, 0, 1,   0,  0, 200, 50,  50, 4);
    add(1, 1, 1,   7,  0,   0,  0,   0, 0);  // reset beats valid and flush
    add(0, 1, 1,   7,  1,   7,  7,   7, 1);
    add(0, 1, 0, 100,  0,   7,  7,   7, 1);  // flush mid-frame with data
    add(0, 1, 1,  20,  1, 120, 20, 100, 2);
    add(0, 0, 0,   0,  0, 120, 20, 100, 2);

    bus.data_i     = '0;
    bus.data_val_i = 1'b0;
    bus.flush_i    = 1'b0;

    foreach (vecs[i]) begin
      srst_i         = vecs[i].rst;
      bus.data_val_i = vecs[i].val;
      bus.flush_i    = vecs[i].flush;
      bus.data_i     = 9'(vecs[i].data);
      @(posedge clk_i);
      #1;
      chk("stats_val", i, int'(bus.stats_val_o), int'(vecs[i].e_val));
      chk("sum",       i, int'(bus.sum_o),       vecs[i].e_sum);
      chk("min",       i, int'(bus.min_o),       vecs[i].e_min);
      chk("max",       i, int'(bus.max_o),       vecs[i].e_max);
      chk("words",     i, int'(bus.words_o),     vecs[i].e_words);
      @(negedge clk_i);
    end

    // Counts 1..4: pulse must appear right after the 4th edge, exactly once.
    srst_i         = 1'b0;
    bus.flush_i    = 1'b0;
    pulses         = 0;
    pulse_cycle    = -1;
    seen_sum       = -1;
    for (int c = 0; c < 10; c++) begin
      bus.data_val_i = (c < 4);
      bus.data_i     = (c < 4) ? 9'(c + 1) : 9'd0;
      @(posedge clk_i);
      #1;
      if (bus.stats_val_o) begin
        pulses++;
        if (pulse_cycle < 0) begin
          pulse_cycle = c;
          seen_sum    = int'(bus.sum_o);
        end
      end
      @(negedge clk_i);
    end
    chk("seq_pulse_count", 0, pulses, 1);
    chk("seq_pulse_cycle", 0, pulse_cycle, 3);
    chk("seq_sum",         0, seen_sum, 10);
    chk("seq_hold_min",    0, int'(bus.min_o), 1);
    chk("seq_hold_max",    0, int'(bus.max_o), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/popcount_frame_stats.md
POPCOUNT_FRAME_STATS -- requirements
Module: popcount_frame_stats

Interface
REQ-001 SHALL have parameter WIDTH, default 256: bit width of the words counted upstream; the input count range is 0..WIDTH.
REQ-002 SHALL have parameter FRAME_LEN, default 16: number of valid counts per frame; legal range 2..1024.
REQ-003 SHALL derive CW = $clog2(WIDTH)+1, SW = $clog2(WIDTH*FRAME_LEN+1) and NW = $clog2(FRAME_LEN+1).
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 srst_i  input  1  reset, synchronous and active-high.
REQ-006 data_i  input  CW  population count of one word, from the upstream bit population counter.
REQ-007 data_val_i  input  1  data_i valid this cycle; there is no backpressure.
REQ-008 flush_i  input  1  closes the current partial frame.
REQ-009 sum_o  output  SW  sum of counts in the last completed frame.
REQ-010 min_o  output  CW  minimum count in the last completed frame.
REQ-011 max_o  output  CW  maximum count in the last completed frame.
REQ-012 words_o  output  NW  number of counts in the last completed frame, 1..FRAME_LEN.
REQ-013 stats_val_o  output  1  one-cycle pulse: sum_o, min_o, max_o and words_o are new.

Function
REQ-014 SHALL implement a 2-state FSM with states IDLE (no counts accumulated) and ACCUM (1..FRAME_LEN-1 counts accumulated).
REQ-015 In IDLE, an accepted count (data_val_i=1) SHALL load the accumulators: sum=data_i, min=data_i, max=data_i, n=1. The FSM SHALL move to ACCUM.
REQ-016 In ACCUM, an accepted count SHALL update the accumulators: sum+=data_i, min=min(min,data_i), max=max(max,data_i), n+=1.
REQ-017 A frame SHALL close on the cycle its FRAME_LEN-th count is accepted; the FSM SHALL then return to IDLE.
REQ-018 When flush_i=1 in ACCUM, the frame SHALL close and include data_i if data_val_i=1 in the same cycle.
REQ-019 When flush_i=1 in IDLE with data_val_i=1, a 1-word frame SHALL close.
REQ-020 When flush_i=1 in IDLE with data_val_i=0, nothing SHALL happen: no pulse and no output change.
REQ-021 If flush_i=1 coincides with the FRAME_LEN-th count, exactly one frame SHALL close with words_o=FRAME_LEN.
REQ-022 On frame close, the final sum/min/max/n (including the closing count) SHALL be registered into the outputs, and stats_val_o SHALL be 1 on the next cycle. Latency is 1 clock from the closing input to the output.
REQ-023 stats_val_o SHALL be high for exactly one cycle per closed frame.
REQ-024 The outputs SHALL hold their values until the next frame closes.
REQ-025 The accumulators for the next frame SHALL start cleanly on the cycle after close. Back-to-back valid counts SHALL be accepted every cycle with no gap lost.
REQ-026 Arithmetic SHALL be unsigned.
REQ-027 sum SHALL never overflow; SW covers WIDTH*FRAME_LEN.
REQ-028 data_i > WIDTH is out of contract; behaviour for such input is unspecified.
REQ-029 When data_val_i=0 and flush_i=0, no state SHALL change.

Reset
REQ-030 While srst_i=1, the following SHALL hold on the next edge: FSM=IDLE; all accumulators 0; sum_o=0, min_o=0, max_o=0, words_o=0, stats_val_o=0.
REQ-031 Reset SHALL override data_val_i and flush_i in the same cycle.
REQ-032 Reset mid-frame SHALL discard the partial frame, with no pulse generated.

Verification (WIDTH=256, FRAME_LEN=4)
REQ-033 Stimulus: counts 10, 200, 0, 256 on consecutive cycles. Required: one cycle after the 4th count, stats_val_o=1 with sum_o=466, min_o=0, max_o=256, words_o=4.
REQ-034 Stimulus: counts 5, 7, then flush_i with data_val_i=0. Required: pulse one cycle later with sum_o=12, min_o=5, max_o=7, words_o=2.
REQ-035 Stimulus: 8 back-to-back counts, all equal to 3. Required: two pulses 4 cycles apart, each with sum_o=12, min_o=3, max_o=3, words_o=4.
REQ-036 Stimulus: flush_i in IDLE with no valid, then flush_i together with count 9. Required: no pulse for the first; a single pulse for the second with sum_o=9, words_o=1.
REQ-037 Stimulus: counts 1, 2, then srst_i, then counts 4, 4, 4, 4. Required: no pulse for the partial frame; one pulse with sum_o=16, words_o=4.
REQ-038 Stimulus: count 50 with flush_i set on the 4th count of a frame. Required: exactly one pulse, with words_o=4.
